// File: rtl/config_regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : config_regfile_pkg                                              |
// | Purpose  : Shared definitions for config_regfile_v2: unlock FSM state      |
// |            encodings, default unlock keys and the key-address helper.      |
// | Ports    : none (package)                                                  |
// | Revision : 2.0 - parametrised successor of the eight-entry register bank   |
// +----------------------------------------------------------------------------+
package config_regfile_pkg;

  // Unlock state encoding. The key/status address reads these values back,
  // so the numbering is visible to software and must stay fixed.
  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_KEY1_OK  = 2'd1;
  localparam logic [1:0] ST_UNLOCKED = 2'd2;

  localparam logic [15:0] DEF_KEY1 = 16'hC0DE;
  localparam logic [15:0] DEF_KEY2 = 16'h5AFE;

  // The key/status register sits directly above the last data register.
  function automatic logic is_key_addr(input int addr, input int num_regs);
    return addr == num_regs;
  endfunction

endpackage : config_regfile_pkg
`default_nettype wire

// File: rtl/cfg_unlock_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cfg_unlock_fsm                                                  |
// | Purpose  : Two-key unlock sequence with inactivity relock. Decides which   |
// |            host writes may reach the shadow registers.                     |
// | Ports    : CLK, RST_N      clock, synchronous active-low reset            |
// |            wren/abus/dbus  host write strobe, address, data               |
// |            wr_permit       write may update shadow[abus] this edge        |
// |            state           current unlock state (for status read-back)    |
// |            locked          high unless UNLOCKED                            |
// |            werr            one-cycle pulse after a rejected write          |
// | Revision : 2.0 - parametrised successor of the eight-entry register bank   |
// +----------------------------------------------------------------------------+
module cfg_unlock_fsm
  import config_regfile_pkg::*;
#(
  parameter int                NUM_REGS   = 8,
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 4,
  parameter logic [DATA_W-1:0] KEY1       = DATA_W'(DEF_KEY1),
  parameter logic [DATA_W-1:0] KEY2       = DATA_W'(DEF_KEY2),
  parameter int                UNLOCK_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wren,
  input  logic [ADDR_W-1:0] abus,
  input  logic [DATA_W-1:0] dbus,
  output logic              wr_permit,
  output logic [1:0]        state,
  output logic              locked,
  output logic              werr
);

  localparam int             c_cnt_w   = (UNLOCK_CYC > 1) ? $clog2(UNLOCK_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_max = c_cnt_w'(UNLOCK_CYC - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_tmo;
  logic [c_cnt_w-1:0] w_tmo_nxt;
  logic               r_werr;
  logic               w_reject;
  logic               w_key;
  logic               w_in_range;

  assign w_key      = is_key_addr(32'(abus), NUM_REGS);
  assign w_in_range = abus < ADDR_W'(NUM_REGS);

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_reject    = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        if (wren) begin
          if (w_key && (dbus == KEY1)) w_state_nxt = ST_KEY1_OK;
          else                         w_reject    = 1'b1;
        end
      end
      ST_KEY1_OK: begin
        // Only the immediately following write may carry KEY2.
        if (wren) begin
          if (w_key && (dbus == KEY2)) begin
            w_state_nxt = ST_UNLOCKED;
          end else begin
            w_state_nxt = ST_LOCKED;
            w_reject    = 1'b1;
          end
        end
      end
      ST_UNLOCKED: begin
        if (wren) begin
          if (w_in_range) begin
            w_tmo_nxt = '0;
          end else if (w_key) begin
            w_state_nxt = ST_LOCKED;
            w_tmo_nxt   = '0;
          end else begin
            // Rejected write neither counts as idle nor restarts the timer.
            w_reject = 1'b1;
          end
        end else if (r_tmo == c_tmo_max) begin
          w_state_nxt = ST_LOCKED;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo + c_cnt_w'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_tmo_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_LOCKED;
      r_tmo   <= '0;
      r_werr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      r_werr  <= w_reject;
    end
  end

  assign wr_permit = wren && (r_state == ST_UNLOCKED) && w_in_range;
  assign state     = r_state;
  assign locked    = (r_state != ST_UNLOCKED);
  assign werr      = r_werr;

endmodule : cfg_unlock_fsm
`default_nettype wire

// File: rtl/config_regfile_v2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : config_regfile_v2                                               |
// | Purpose  : NUM_REGS x DATA_W configuration bank. Host writes go to shadow |
// |            copies guarded by a two-key unlock; COMMIT copies all shadows  |
// |            to the active outputs. Registered read-back of active values.  |
// | Ports    : CLK, RST_N            clock, synchronous active-low reset      |
// |            WREN/ABUS/DBUS        host write                                |
// |            COMMIT/COMMIT_ACK     shadow->active copy and its ack pulse    |
// |            RDEN/RABUS/RDATA/RVALID  registered read-back                  |
// |            CFG_OUT               flattened active registers               |
// |            LOCKED/WERR           lock status, rejected-write pulse        |
// |            PERR                  sticky parity error (optional)           |
// | Options  : CONFIG_REGFILE_PARITY_EN adds per-register parity and PERR.    |
// | Revision : 2.0 - parametrised successor of the eight-entry register bank   |
// +----------------------------------------------------------------------------+
module config_regfile_v2
  import config_regfile_pkg::*;
#(
  parameter int                         NUM_REGS   = 8,
  parameter int                         DATA_W     = 16,
  parameter int                         ADDR_W     = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS   = '0,
  parameter logic [DATA_W-1:0]          KEY1       = DATA_W'(DEF_KEY1),
  parameter logic [DATA_W-1:0]          KEY2       = DATA_W'(DEF_KEY2),
  parameter int                         UNLOCK_CYC = 1024
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         WREN,
  input  logic [ADDR_W-1:0]            ABUS,
  input  logic [DATA_W-1:0]            DBUS,
  input  logic                         COMMIT,
  output logic                         COMMIT_ACK,
  input  logic                         RDEN,
  input  logic [ADDR_W-1:0]            RABUS,
  output logic [DATA_W-1:0]            RDATA,
  output logic                         RVALID,
  output logic [NUM_REGS*DATA_W-1:0]   CFG_OUT,
  output logic                         LOCKED,
  output logic                         WERR
`ifdef CONFIG_REGFILE_PARITY_EN
  ,
  output logic                         PERR
`endif
);

  logic [DATA_W-1:0] r_shadow     [NUM_REGS];
  logic [DATA_W-1:0] r_active     [NUM_REGS];
  logic [DATA_W-1:0] w_commit_val [NUM_REGS];
  logic              w_wr_permit;
  logic [1:0]        w_state;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_ack;

  cfg_unlock_fsm #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .KEY1       (KEY1),
    .KEY2       (KEY2),
    .UNLOCK_CYC (UNLOCK_CYC)
  ) u_fsm (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .wren      (WREN),
    .abus      (ABUS),
    .dbus      (DBUS),
    .wr_permit (w_wr_permit),
    .state     (w_state),
    .locked    (LOCKED),
    .werr      (WERR)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic w_hit;
    assign w_hit = w_wr_permit && (ABUS == ADDR_W'(i));

    // A write accepted in the commit cycle is forwarded so it lands in the
    // committed value rather than waiting for the next commit.
    assign w_commit_val[i] = w_hit ? DBUS : r_shadow[i];

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        r_shadow[i] <= RST_VALS[i*DATA_W +: DATA_W];
        r_active[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end else begin
        if (w_hit)  r_shadow[i] <= DBUS;
        if (COMMIT) r_active[i] <= w_commit_val[i];
      end
    end

    assign CFG_OUT[i*DATA_W +: DATA_W] = r_active[i];
  end

  // Read mux samples active values before this edge's commit takes effect.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RABUS == ADDR_W'(i)) w_rd = r_active[i];
    end
    if (is_key_addr(32'(RABUS), NUM_REGS)) w_rd = DATA_W'(w_state);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_rvalid <= RDEN;
      r_ack    <= COMMIT;
      if (RDEN) r_rdata <= w_rd;
    end
  end

  assign RDATA      = r_rdata;
  assign RVALID     = r_rvalid;
  assign COMMIT_ACK = r_ack;

`ifdef CONFIG_REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] r_par;
  logic [NUM_REGS-1:0] w_par_bad;
  logic                r_perr;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_par
    // Even parity: stored bit makes the total number of ones even.
    always_ff @(posedge CLK) begin
      if (!RST_N)      r_par[i] <= ^RST_VALS[i*DATA_W +: DATA_W];
      else if (COMMIT) r_par[i] <= ^w_commit_val[i];
    end
    assign w_par_bad[i] = (^r_active[i]) != r_par[i];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)            r_perr <= 1'b0;
    else if (COMMIT)       r_perr <= 1'b0;
    else if (|w_par_bad)   r_perr <= 1'b1;
  end

  assign PERR = r_perr;
`endif

endmodule : config_regfile_v2
`default_nettype wire
